mul_ucode_seq: RTL and testbench
================================

Name: mul_ucode_seq

Overview:
- Consumer end of the decoder's multiply request interface (mul_trigger, mul_type, dest/src fields, imm).
- Expands one decoded muli/mulr/mulsi/mulsr into a multi-cycle micro-sequence: register-file read, radix-2 shift-add iterations, sign fix, register writeback.
- Holds the front end via stall while the sequence runs.
- Sits between the decode stage and the register file, alongside the ALU writeback path.

Parameters:
DATA_W, 32, register/operand width
REG_AW, 4, register address width (16 registers)
IMM_W, 16, immediate width from decode

Ports:
clk  in  1  clock
rst  in  1  synchronous active-low reset
mul_trigger  in  1  multiply request from decode, level, held while stall=1
mul_type  in  2  0=muli, 1=mulr, 2=mulsi, 3=mulsr (bit1=signed, bit0=register operand)
dest_reg  in  REG_AW  destination register
src1_reg  in  REG_AW  operand A register
src2_reg  in  REG_AW  operand B register (register forms only)
imm  in  IMM_W  operand B immediate (immediate forms only)
rf_raddr1  out  REG_AW  RF read address A
rf_raddr2  out  REG_AW  RF read address B
rf_rdata1  in  DATA_W  RF read data A (combinational read)
rf_rdata2  in  DATA_W  RF read data B (combinational read)
rf_we  out  1  RF write enable, one-cycle pulse
rf_waddr  out  REG_AW  RF write address
rf_wdata  out  DATA_W  low word of product
prod_hi  out  DATA_W  high word of product, valid from done until next done
flag_z  out  1  low word == 0, updated at done
flag_n  out  1  low word MSB, updated at done
busy  out  1  sequence in progress
stall  out  1  hold fetch/decode
done  out  1  one-cycle completion pulse, coincident with rf_we

Behaviour:
- Reset (rst=0 at posedge):
  - state=IDLE.
  - All outputs 0, including prod_hi and flags.
  - Internal operand, accumulator and counter registers 0.
- FSM states: IDLE, READ, MUL, SIGN, WB.
- IDLE:
  - stall=busy=0.
  - If mul_trigger=1: latch mul_type, dest_reg, src1_reg, src2_reg and imm; go to READ.
- READ (1 cycle):
  - rf_raddr1=latched src1; rf_raddr2=latched src2.
  - Operand A = rf_rdata1.
  - Operand B: register forms use rf_rdata2; imm forms use imm, sign-extended if signed, else zero-extended.
  - Signed forms: store magnitudes |A| and |B|, and neg = sign(A) XOR sign(B).
  - Unsigned forms: neg=0.
  - Clear the 2*DATA_W accumulator; count=0; go to MUL.
- MUL (exactly DATA_W cycles):
  - Each cycle: if multiplier LSB=1, add multiplicand into the upper half of the accumulator; shift right by 1 (carry retained).
  - count increments; after count==DATA_W-1, go to SIGN.
- SIGN (1 cycle): if neg, accumulator = two's-complement negate over 2*DATA_W bits.
- WB (1 cycle):
  - rf_we=1, rf_waddr=latched dest, rf_wdata=acc[DATA_W-1:0].
  - prod_hi, flag_z and flag_n registered; done=1.
  - Next state IDLE.
- Latency:
  - Trigger sampled at edge T: READ in T+1, MUL T+2..T+1+DATA_W, SIGN T+2+DATA_W, WB T+3+DATA_W.
  - For DATA_W=32, rf_we asserts 35 cycles after acceptance.
- stall=busy=1 in READ, MUL, SIGN and WB.
- rf_raddr*: driven with latched values in all non-IDLE states; 0 in IDLE.
- Boundary conditions:
  - mul_trigger while busy, including during WB: ignored. A still-held trigger is accepted on the first IDLE cycle, so decode's held request yields exactly one operation.
  - dest equal to a source register: safe, because operands are captured in READ before writeback.
  - Operand value -2^(DATA_W-1) in signed forms: magnitude is treated as unsigned 2^(DATA_W-1); the result is still correct.
  - Operand 0: full sequence still runs (no early exit); flag_z=1.
  - Reset mid-operation (any state): return to IDLE next edge, no rf_we, prod_hi and flags cleared.
- Product is a full 2*DATA_W result. Signedness affects prod_hi and the immediate extension; the low word is identical to the low word of the unsigned product of the extended operands.

Decomposition:
- Shared package:
  - mul_type encodings: MUL_I=0, MUL_R=1, MUL_SI=2, MUL_SR=3.
  - FSM state encoding.
  - DATA_W/REG_AW/IMM_W defaults.
- Sub-module: mul_shift_add_dp holds the operand/magnitude registers, accumulator, shift-add step and sign negate. Controlled by load/step/fix strobes from the FSM in mul_ucode_seq.

Test Plan:
- muli: R3=7, imm=6, dest=R5 -> rf_we at T+35, rf_waddr=5, rf_wdata=42, prod_hi=0, flag_z=0, flag_n=0; stall high T+1..T+35.
- mulsi: R1=0xFFFFFFFD (-3), imm=0xFFFE (-2) -> rf_wdata=6, prod_hi=0. Same operands as muli (type 0) -> imm zero-extended, rf_wdata=0xFFFFFFFD*0xFFFE low word, prod_hi=0x0000FFFD.
- mulr vs mulsr: R1=0xFFFFFFFF, R2=2. mulr -> lo=0xFFFFFFFE, hi=0x00000001. mulsr -> lo=0xFFFFFFFE, hi=0xFFFFFFFF, flag_n=1.
- Zero and self-dest: mulsr R4=R4*R0 with R0=0, dest=R4 -> rf_wdata=0, flag_z=1, written to R4 at T+35.
- Held trigger: mul_trigger held high for 40 cycles -> exactly one accepted op plus a second accepted only at the IDLE cycle after done; no acceptance during busy cycles.
- Reset mid-MUL: rst=0 at T+10 for one cycle -> no rf_we or done ever pulses; all outputs 0; next trigger completes normally 35 cycles later.

Source files
------------

// File: rtl/mul_ucode_seq_pkg.sv
// Shared definitions for the multiply micro-sequencer: operation encodings,
// FSM states and default widths.
package mul_ucode_seq_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int REG_AW_DEF = 4;
  localparam int IMM_W_DEF  = 16;

  // bit1 = signed, bit0 = register operand
  typedef enum logic [1:0] {
    MUL_I  = 2'd0,
    MUL_R  = 2'd1,
    MUL_SI = 2'd2,
    MUL_SR = 2'd3
  } mul_type_e;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_READ = 3'd1,
    ST_MUL  = 3'd2,
    ST_SIGN = 3'd3,
    ST_WB   = 3'd4
  } state_e;

endpackage

// File: rtl/mul_shift_add_dp.sv
// Radix-2 shift-add multiplier datapath: magnitude capture, one add/shift per
// step strobe, and a final two's-complement fix when the signs differed.
module mul_shift_add_dp #(
  parameter int DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load_i,
  input  logic                  step_i,
  input  logic                  fix_i,
  input  logic                  signed_i,
  input  logic [DATA_W-1:0]     op_a_i,
  input  logic [DATA_W-1:0]     op_b_i,
  output logic [2*DATA_W-1:0]   acc_o,
  output logic [2*DATA_W-1:0]   fixed_o
);

  localparam int PW = 2 * DATA_W;

  logic [DATA_W-1:0] a_q, b_q;
  logic              neg_q;
  logic [PW-1:0]     acc_q;

  logic              a_neg, b_neg;
  logic [DATA_W-1:0] mag_a, mag_b;
  logic [DATA_W:0]   sum;

  // -2^(DATA_W-1) negates to itself, which read as unsigned is the true magnitude.
  always_comb begin
    a_neg   = signed_i & op_a_i[DATA_W-1];
    b_neg   = signed_i & op_b_i[DATA_W-1];
    mag_a   = a_neg ? (~op_a_i + {{(DATA_W-1){1'b0}}, 1'b1}) : op_a_i;
    mag_b   = b_neg ? (~op_b_i + {{(DATA_W-1){1'b0}}, 1'b1}) : op_b_i;
    sum     = {1'b0, acc_q[PW-1:DATA_W]} + (b_q[0] ? {1'b0, a_q} : {(DATA_W+1){1'b0}});
    fixed_o = neg_q ? (~acc_q + {{(PW-1){1'b0}}, 1'b1}) : acc_q;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      a_q   <= '0;
      b_q   <= '0;
      neg_q <= 1'b0;
      acc_q <= '0;
    end else if (load_i) begin
      a_q   <= mag_a;
      b_q   <= mag_b;
      neg_q <= a_neg ^ b_neg;
      acc_q <= '0;
    end else if (step_i) begin
      // Carry out of the upper-half add becomes the new MSB after the shift.
      acc_q <= {sum, acc_q[DATA_W-1:1]};
      b_q   <= b_q >> 1;
    end else if (fix_i) begin
      acc_q <= fixed_o;
    end
  end

  assign acc_o = acc_q;

endmodule

// File: rtl/mul_ucode_seq.sv
// Multiply micro-sequencer: accepts one decoded multiply, reads the register
// file, runs DATA_W shift-add steps, fixes the sign and writes the low word back.
module mul_ucode_seq
  import mul_ucode_seq_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int REG_AW = REG_AW_DEF,
  parameter int IMM_W  = IMM_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mul_trigger,
  input  logic [1:0]        mul_type,
  input  logic [REG_AW-1:0] dest_reg,
  input  logic [REG_AW-1:0] src1_reg,
  input  logic [REG_AW-1:0] src2_reg,
  input  logic [IMM_W-1:0]  imm,
  output logic [REG_AW-1:0] rf_raddr1,
  output logic [REG_AW-1:0] rf_raddr2,
  input  logic [DATA_W-1:0] rf_rdata1,
  input  logic [DATA_W-1:0] rf_rdata2,
  output logic              rf_we,
  output logic [REG_AW-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic [DATA_W-1:0] prod_hi,
  output logic              flag_z,
  output logic              flag_n,
  output logic              busy,
  output logic              stall,
  output logic              done
);

  localparam int CNT_W = $clog2(DATA_W);

  state_e            state_q, state_d;
  mul_type_e         type_q, type_d;
  logic [REG_AW-1:0] dest_q, dest_d, src1_q, src1_d, src2_q, src2_d;
  logic [IMM_W-1:0]  imm_q, imm_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] prod_hi_q;
  logic              flag_z_q, flag_n_q;

  logic                load, step, fix;
  logic [DATA_W-1:0]   op_b;
  logic [2*DATA_W-1:0] acc, fixed;

  always_comb begin
    state_d = state_q;
    type_d  = type_q;
    dest_d  = dest_q;
    src1_d  = src1_q;
    src2_d  = src2_q;
    imm_d   = imm_q;
    cnt_d   = cnt_q;
    load    = 1'b0;
    step    = 1'b0;
    fix     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (mul_trigger) begin
          type_d  = mul_type_e'(mul_type);
          dest_d  = dest_reg;
          src1_d  = src1_reg;
          src2_d  = src2_reg;
          imm_d   = imm;
          state_d = ST_READ;
        end
      end
      ST_READ: begin
        load    = 1'b1;
        cnt_d   = '0;
        state_d = ST_MUL;
      end
      ST_MUL: begin
        step  = 1'b1;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(DATA_W - 1)) state_d = ST_SIGN;
      end
      ST_SIGN: begin
        fix     = 1'b1;
        state_d = ST_WB;
      end
      ST_WB:   state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      type_q    <= MUL_I;
      dest_q    <= '0;
      src1_q    <= '0;
      src2_q    <= '0;
      imm_q     <= '0;
      cnt_q     <= '0;
      prod_hi_q <= '0;
      flag_z_q  <= 1'b0;
      flag_n_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      type_q  <= type_d;
      dest_q  <= dest_d;
      src1_q  <= src1_d;
      src2_q  <= src2_d;
      imm_q   <= imm_d;
      cnt_q   <= cnt_d;
      // Loaded from the sign-fixed product so they are valid in the done cycle.
      if (fix) begin
        prod_hi_q <= fixed[2*DATA_W-1:DATA_W];
        flag_z_q  <= (fixed[DATA_W-1:0] == '0);
        flag_n_q  <= fixed[DATA_W-1];
      end
    end
  end

  always_comb begin
    if (type_q == MUL_R || type_q == MUL_SR) op_b = rf_rdata2;
    else if (type_q == MUL_SI)               op_b = {{(DATA_W-IMM_W){imm_q[IMM_W-1]}}, imm_q};
    else                                     op_b = {{(DATA_W-IMM_W){1'b0}}, imm_q};
  end

  mul_shift_add_dp #(.DATA_W(DATA_W)) u_dp (
    .clk      (clk),
    .rst      (rst),
    .load_i   (load),
    .step_i   (step),
    .fix_i    (fix),
    .signed_i (type_q == MUL_SI || type_q == MUL_SR),
    .op_a_i   (rf_rdata1),
    .op_b_i   (op_b),
    .acc_o    (acc),
    .fixed_o  (fixed)
  );

  assign busy      = (state_q != ST_IDLE);
  assign stall     = busy;
  assign rf_raddr1 = busy ? src1_q : '0;
  assign rf_raddr2 = busy ? src2_q : '0;
  assign rf_we     = (state_q == ST_WB);
  assign done      = rf_we;
  assign rf_waddr  = rf_we ? dest_q : '0;
  assign rf_wdata  = rf_we ? acc[DATA_W-1:0] : '0;
  assign prod_hi   = prod_hi_q;
  assign flag_z    = flag_z_q;
  assign flag_n    = flag_n_q;

endmodule

// File: tb/tb_mul_ucode_seq.sv
// Bench for mul_ucode_seq: a register-file model, a driver issuing directed and
// random multiplies, and a monitor checking writebacks against a queue.
module tb_mul_ucode_seq;

  localparam int EXP_W = 4 + 32 + 32 + 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        mul_trigger;
  logic [1:0]  mul_type;
  logic [3:0]  dest_reg, src1_reg, src2_reg;
  logic [15:0] imm;
  logic [3:0]  rf_raddr1, rf_raddr2, rf_waddr;
  logic [31:0] rf_rdata1, rf_rdata2, rf_wdata, prod_hi;
  logic        rf_we, flag_z, flag_n, busy, stall, done;

  // clock / cycle counter
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  mul_ucode_seq dut (
    .clk(clk), .rst(rst), .mul_trigger(mul_trigger), .mul_type(mul_type),
    .dest_reg(dest_reg), .src1_reg(src1_reg), .src2_reg(src2_reg), .imm(imm),
    .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2),
    .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .prod_hi(prod_hi),
    .flag_z(flag_z), .flag_n(flag_n), .busy(busy), .stall(stall), .done(done)
  );

  // register file seen by the DUT, plus a backdoor for preloading
  logic [31:0] rf [16];
  logic [31:0] model_rf [16];
  logic        bd_we = 1'b0;
  logic [3:0]  bd_addr = '0;
  logic [31:0] bd_data = '0;
  always @(posedge clk) begin
    if (bd_we) rf[bd_addr] <= bd_data;
    if (rf_we) rf[rf_waddr] <= rf_wdata;
  end
  assign rf_rdata1 = rf[rf_raddr1];
  assign rf_rdata2 = rf[rf_raddr2];

  // scoreboard state
  logic [EXP_W-1:0] exp_q[$];
  int               exp_cyc_q[$];
  int               n_vec = 0;
  int               n_fail = 0;
  int               busy_start = 0;
  int               busy_end = -1;
  logic             mon_en = 1'b0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp_v);
    n_vec++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp_v, cyc);
    end
  endtask

  // reference: full product of the extended operands, modulo 2^64
  task automatic push_exp(input logic [1:0] t, input logic [3:0] d, input logic [3:0] s1,
                          input logic [3:0] s2, input logic [15:0] im, input int done_cyc);
    logic [31:0] a, b;
    logic [63:0] ax, bx, p;
    a = model_rf[s1];
    if (t[0]) b = model_rf[s2];
    else      b = t[1] ? {{16{im[15]}}, im} : {16'h0, im};
    ax = t[1] ? {{32{a[31]}}, a} : {32'h0, a};
    bx = t[1] ? {{32{b[31]}}, b} : {32'h0, b};
    p  = ax * bx;
    exp_q.push_back({d, p[31:0], p[63:32], (p[31:0] == 32'h0), p[31]});
    exp_cyc_q.push_back(done_cyc);
    model_rf[d] = p[31:0];
  endtask

  // monitor
  logic             exp_b;
  logic [EXP_W-1:0] e;
  int               ec;
  always @(negedge clk) begin
    if (mon_en && rst) begin
      exp_b = (cyc >= busy_start) && (cyc <= busy_end);
      check("busy", 64'(busy), 64'(exp_b));
      check("stall", 64'(stall), 64'(exp_b));
      check("done_vs_we", 64'(done), 64'(rf_we));
      if (done) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_fail++;
          $display("FAIL unexpected_done: got done=1 expected none (cycle %0d)", cyc);
        end else begin
          e  = exp_q.pop_front();
          ec = exp_cyc_q.pop_front();
          check("done_cycle", 64'(cyc), 64'(ec));
          check("rf_waddr", 64'(rf_waddr), 64'(e[69:66]));
          check("rf_wdata", 64'(rf_wdata), 64'(e[65:34]));
          check("prod_hi", 64'(prod_hi), 64'(e[33:2]));
          check("flag_z", 64'(flag_z), 64'(e[1]));
          check("flag_n", 64'(flag_n), 64'(e[0]));
        end
      end
    end
  end

  // driver tasks (all act at posedge + 1)
  task automatic scramble();
    mul_type = 2'($urandom);
    dest_reg = 4'($urandom);
    src1_reg = 4'($urandom);
    src2_reg = 4'($urandom);
    imm      = 16'($urandom);
  endtask

  task automatic set_reg(input logic [3:0] r, input logic [31:0] v);
    bd_we = 1'b1; bd_addr = r; bd_data = v;
    model_rf[r] = v;
    @(posedge clk); #1;
    bd_we = 1'b0;
  endtask

  task automatic wait_idle();
    while (cyc < busy_end + 1) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic issue(input logic [1:0] t, input logic [3:0] d, input logic [3:0] s1,
                       input logic [3:0] s2, input logic [15:0] im);
    mul_type = t; dest_reg = d; src1_reg = s1; src2_reg = s2; imm = im;
    mul_trigger = 1'b1;
    busy_start = cyc + 1;
    busy_end   = cyc + 35;
    push_exp(t, d, s1, s2, im, cyc + 35);
    @(posedge clk); #1;
    mul_trigger = 1'b0;
    scramble();
    wait_idle();
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_rf_we"}, 64'(rf_we), 64'(0));
    check({tag, "_done"}, 64'(done), 64'(0));
    check({tag, "_busy"}, 64'(busy), 64'(0));
    check({tag, "_stall"}, 64'(stall), 64'(0));
    check({tag, "_raddr1"}, 64'(rf_raddr1), 64'(0));
    check({tag, "_raddr2"}, 64'(rf_raddr2), 64'(0));
    check({tag, "_waddr"}, 64'(rf_waddr), 64'(0));
    check({tag, "_wdata"}, 64'(rf_wdata), 64'(0));
    check({tag, "_prod_hi"}, 64'(prod_hi), 64'(0));
    check({tag, "_flag_z"}, 64'(flag_z), 64'(0));
    check({tag, "_flag_n"}, 64'(flag_n), 64'(0));
  endtask

  initial begin
    #500000;
    $display("FAIL timeout: got no finish expected finish (cycle %0d)", cyc);
    $fatal(1, "timeout");
  end

  int a_cyc;
  int c0;
  initial begin
    rst = 1'b0;
    mul_trigger = 1'b0;
    mul_type = '0; dest_reg = '0; src1_reg = '0; src2_reg = '0; imm = '0;
    @(posedge clk); #1;
    for (int i = 0; i < 16; i++) set_reg(4'(i), $urandom);
    @(negedge clk);
    check_all_zero("reset");
    @(posedge clk); #1;
    rst = 1'b1;
    mon_en = 1'b1;

    // muli 7*6
    set_reg(4'd3, 32'd7);
    issue(2'd0, 4'd5, 4'd3, 4'd0, 16'd6);
    // mulsi -3*-2, then the same operands with zero-extended imm
    set_reg(4'd1, 32'hFFFF_FFFD);
    issue(2'd2, 4'd6, 4'd1, 4'd0, 16'hFFFE);
    issue(2'd0, 4'd6, 4'd1, 4'd0, 16'hFFFE);
    // mulr vs mulsr of 0xFFFFFFFF * 2
    set_reg(4'd1, 32'hFFFF_FFFF);
    set_reg(4'd2, 32'd2);
    issue(2'd1, 4'd7, 4'd1, 4'd2, 16'd0);
    issue(2'd3, 4'd8, 4'd1, 4'd2, 16'd0);

    // reset during MUL: operation abandoned, outputs and flags cleared
    mul_type = 2'd3; dest_reg = 4'd3; src1_reg = 4'd1; src2_reg = 4'd2; imm = '0;
    mul_trigger = 1'b1;
    busy_start = cyc + 1;
    busy_end   = cyc + 35;
    @(posedge clk); #1;
    mul_trigger = 1'b0;
    a_cyc = cyc;
    while (cyc < a_cyc + 9) begin
      @(posedge clk); #1;
    end
    rst = 1'b0;
    busy_end = cyc;
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    check_all_zero("midreset");
    repeat (40) begin
      @(posedge clk); #1;
    end
    issue(2'd3, 4'd3, 4'd1, 4'd2, 16'd0);

    // zero operand with dest == src1
    set_reg(4'd0, 32'd0);
    set_reg(4'd4, $urandom | 32'd1);
    issue(2'd3, 4'd4, 4'd4, 4'd0, 16'd0);

    // most-negative operand in signed forms
    set_reg(4'd10, 32'h8000_0000);
    set_reg(4'd11, 32'h8000_0000);
    set_reg(4'd12, 32'hFFFF_FFFF);
    issue(2'd3, 4'd13, 4'd10, 4'd11, 16'd0);
    issue(2'd3, 4'd14, 4'd10, 4'd12, 16'd0);
    issue(2'd2, 4'd15, 4'd10, 4'd0, 16'h8000);

    // trigger held for 40 cycles: second op accepted only in the IDLE after done
    set_reg(4'd2, 32'd5);
    set_reg(4'd9, 32'd3);
    mul_type = 2'd1; dest_reg = 4'd2; src1_reg = 4'd2; src2_reg = 4'd9; imm = '0;
    mul_trigger = 1'b1;
    c0 = cyc;
    a_cyc = cyc + 1;
    busy_start = a_cyc;
    busy_end   = a_cyc + 34;
    push_exp(2'd1, 4'd2, 4'd2, 4'd9, 16'd0, a_cyc + 34);
    while (cyc < a_cyc + 35) begin
      @(posedge clk); #1;
    end
    busy_start = a_cyc + 36;
    busy_end   = a_cyc + 70;
    push_exp(2'd1, 4'd2, 4'd2, 4'd9, 16'd0, a_cyc + 70);
    while (cyc < c0 + 40) begin
      @(posedge clk); #1;
    end
    mul_trigger = 1'b0;
    wait_idle();

    // random operations
    for (int k = 0; k < 20; k++) begin
      if ($urandom_range(0, 1) == 1) begin
        case ($urandom_range(0, 3))
          0:       set_reg(4'($urandom), 32'h0);
          1:       set_reg(4'($urandom), 32'h8000_0000);
          2:       set_reg(4'($urandom), 32'hFFFF_FFFF);
          default: set_reg(4'($urandom), $urandom);
        endcase
      end
      issue(2'($urandom_range(0, 3)), 4'($urandom), 4'($urandom), 4'($urandom), 16'($urandom));
    end

    repeat (5) begin
      @(posedge clk); #1;
    end
    check("pending_expectations", 64'(exp_q.size()), 64'(0));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
